// File: rtl/rs_scheduler_pkg.sv
// rs_scheduler_pkg: shared reservation-station sizing and scheduler state encoding
package rs_scheduler_pkg;
  localparam int RS_SIZE = 8;
  localparam int RS_IDX_W = $clog2(RS_SIZE);
  typedef enum logic {RUN, FLUSH} RS_STATE;
endpackage

// File: rtl/rs_scheduler_rr_select.sv
// rr_select: round-robin pick of the first request at or above ptr, wrapping modulo W
module rr_select #(
  parameter int W = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_valid = |req;
    gnt_idx = '0;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      idx = ptr + IW'(i);
      if (req[idx]) gnt_idx = idx;
    end
  end
endmodule

// File: rtl/rs_scheduler.sv
// rs_scheduler: allocates free RS entries, issues ready ones round-robin, tracks occupancy
module rs_scheduler #(
  parameter int RS_SIZE = rs_scheduler_pkg::RS_SIZE,
  parameter int IDX_W = $clog2(RS_SIZE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_valid,
  input  logic               squash,
  input  logic [RS_SIZE-1:0] entry_busy,
  input  logic [RS_SIZE-1:0] entry_ready,
  input  logic               fu_ready,
  output logic [RS_SIZE-1:0] entry_wr_en,
  output logic [RS_SIZE-1:0] entry_clear,
  output logic               dispatch_stall,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   issue_idx,
  output logic [IDX_W:0]     occupancy
);
  import rs_scheduler_pkg::*;
  localparam int OW = IDX_W + 1;
  RS_STATE state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, sel_idx;
  logic [OW-1:0] occupancy_q, occupancy_d;
  logic [RS_SIZE-1:0] free, cand;
  logic sel_valid, run, issue_fire, alloc;
  assign occupancy = occupancy_q;
  assign cand = entry_busy & entry_ready;
  assign run = !reset && state_q == RUN && !squash;
  rr_select #(.W(RS_SIZE)) u_issue_sel (
    .req(cand),
    .ptr(rr_ptr_q),
    .gnt_valid(sel_valid),
    .gnt_idx(sel_idx)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      rr_ptr_q <= '0;
      occupancy_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      occupancy_q <= occupancy_d;
    end
  end
  always_comb state_d = squash ? FLUSH : RUN;
  // an entry cleared this cycle stays out of the free mask until it reads not-busy
  always_comb begin
    issue_valid = run && sel_valid;
    issue_idx = issue_valid ? sel_idx : '0;
    issue_fire = issue_valid && fu_ready;
    entry_clear = reset ? '0 : squash ? '1 : issue_fire ? RS_SIZE'(1) << issue_idx : '0;
    free = ~entry_busy & ~entry_clear;
    entry_wr_en = (run && dispatch_valid) ? free & (~free + 1'b1) : '0;
    alloc = |entry_wr_en;
    dispatch_stall = reset || free == '0 || squash || state_q == FLUSH;
  end
  always_comb begin
    rr_ptr_d = squash ? '0 : issue_fire ? sel_idx + 1'b1 : rr_ptr_q;
    occupancy_d = squash ? '0 : occupancy_q + OW'(alloc) - OW'(issue_fire);
  end
endmodule

// File: tb/tb_rs_scheduler.sv
// tb_rs_scheduler: directed bench with a behavioural entry model and an issue-order scoreboard
module tb_rs_scheduler;
  import rs_scheduler_pkg::*;
  logic clock = 1'b0;
  logic reset, dispatch_valid, squash, fu_ready, rdy_new;
  logic [7:0] entry_busy, entry_ready, entry_wr_en, entry_clear;
  logic dispatch_stall, issue_valid;
  logic [2:0] issue_idx;
  logic [3:0] occupancy;
  int total = 0;
  int bad = 0;
  int exp_q[$];

  rs_scheduler dut (
    .clock(clock),
    .reset(reset),
    .dispatch_valid(dispatch_valid),
    .squash(squash),
    .entry_busy(entry_busy),
    .entry_ready(entry_ready),
    .fu_ready(fu_ready),
    .entry_wr_en(entry_wr_en),
    .entry_clear(entry_clear),
    .dispatch_stall(dispatch_stall),
    .issue_valid(issue_valid),
    .issue_idx(issue_idx),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic tick;
    logic [7:0] wr, clr;
    #1;
    wr = entry_wr_en;
    clr = entry_clear;
    if (!reset) chk("occ_inv", 32'(occupancy), $countones(entry_busy));
    @(posedge clock);
    #1;
    entry_busy = (entry_busy & ~clr) | wr;
    entry_ready = (entry_ready & ~clr) | (wr & {8{rdy_new}});
  endtask

  task automatic drain(input int budget);
    int n;
    int e;
    logic [7:0] m;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      settle;
      if (issue_valid && fu_ready) begin
        e = exp_q.pop_front();
        m = 8'b1 << e;
        chk("issue_idx", 32'(issue_idx), e);
        chk("issue_clear", 32'(entry_clear), 32'(m));
      end
      tick;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    rdy_new = 1'b0;
    for (int c = 0; c < 2; c++) begin
      dispatch_valid = 1'($urandom);
      squash = 1'($urandom);
      fu_ready = 1'($urandom);
      entry_busy = 8'($urandom);
      entry_ready = 8'($urandom);
      settle;
      chk("rst_wr", 32'(entry_wr_en), 0);
      chk("rst_clear", 32'(entry_clear), 0);
      chk("rst_valid", 32'(issue_valid), 0);
      chk("rst_idx", 32'(issue_idx), 0);
      chk("rst_stall", 32'(dispatch_stall), 1);
      tick;
      chk("rst_occ", 32'(occupancy), 0);
    end
    reset = 1'b0;
    squash = 1'b0;
    fu_ready = 1'b0;
    dispatch_valid = 1'b1;
    entry_busy = 8'h00;
    entry_ready = 8'h00;
    for (int i = 0; i < 8; i++) begin
      settle;
      chk("fill_wr", 32'(entry_wr_en), 32'(8'b1 << i));
      chk("fill_stall", 32'(dispatch_stall), 0);
      tick;
    end
    settle;
    chk("full_stall", 32'(dispatch_stall), 1);
    chk("full_occ", 32'(occupancy), 8);
    chk("full_wr", 32'(entry_wr_en), 0);
    entry_ready = 8'h01;
    fu_ready = 1'b1;
    settle;
    chk("full_issue_valid", 32'(issue_valid), 1);
    chk("full_issue_clear", 32'(entry_clear), 32'h01);
    chk("full_issue_stall", 32'(dispatch_stall), 1);
    chk("full_issue_wr", 32'(entry_wr_en), 0);
    tick;
    settle;
    chk("resume_wr", 32'(entry_wr_en), 32'h01);
    chk("resume_stall", 32'(dispatch_stall), 0);
    tick;
    dispatch_valid = 1'b0;
    entry_ready = 8'hDA;
    exp_q = '{1, 3, 4, 6, 7};
    drain(20);
    settle;
    chk("rr_pre_occ", 32'(occupancy), 3);
    entry_ready = 8'h25;
    exp_q = '{0, 2, 5};
    drain(20);
    settle;
    chk("rr_post_occ", 32'(occupancy), 0);
    chk("rr_ptr_after5", 32'(dut.rr_ptr_q), 6);
    dispatch_valid = 1'b1;
    repeat (7) tick;
    dispatch_valid = 1'b0;
    entry_ready = 8'h41;
    exp_q = '{6, 0};
    drain(10);
    entry_ready = 8'h08;
    fu_ready = 1'b0;
    repeat (3) begin
      settle;
      chk("hold_valid", 32'(issue_valid), 1);
      chk("hold_idx", 32'(issue_idx), 3);
      chk("hold_clear", 32'(entry_clear), 0);
      chk("hold_ptr", 32'(dut.rr_ptr_q), 1);
      tick;
    end
    dispatch_valid = 1'b1;
    fu_ready = 1'b1;
    squash = 1'b1;
    settle;
    chk("sq_pre_occ", 32'(occupancy), 5);
    chk("sq_clear", 32'(entry_clear), 32'hFF);
    chk("sq_wr", 32'(entry_wr_en), 0);
    chk("sq_valid", 32'(issue_valid), 0);
    chk("sq_stall", 32'(dispatch_stall), 1);
    tick;
    squash = 1'b0;
    settle;
    chk("flush_state", 32'(dut.state_q == FLUSH), 1);
    chk("flush_stall", 32'(dispatch_stall), 1);
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_wr", 32'(entry_wr_en), 0);
    tick;
    settle;
    chk("run_state", 32'(dut.state_q == RUN), 1);
    chk("run_stall", 32'(dispatch_stall), 0);
    chk("run_wr", 32'(entry_wr_en), 32'h01);
    tick;
    squash = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    squash = 1'b0;
    entry_busy = 8'h00;
    entry_ready = 8'h00;
    settle;
    chk("rst_sq_state", 32'(dut.state_q == RUN), 1);
    chk("rst_sq_occ", 32'(occupancy), 0);
    chk("rst_sq_stall", 32'(dispatch_stall), 0);
    dispatch_valid = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
